// File: rtl/rand_seq_checker.sv
// Monitor for the 14-entry 4-bit pseudo-random sequence: acquires alignment,
// locks, then checks each qualified sample and reports matches/errors.
module rand_seq_checker #(
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 3,
  parameter int ERR_W         = 8,
  parameter int MATCH_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [3:0]         sample,
  input  logic               clear,
  output logic               locked,
  output logic               error_pulse,
  output logic               period_pulse,
  output logic [ERR_W-1:0]   err_count,
  output logic [MATCH_W-1:0] match_count,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] LOCK_T   = 4'(LOCK_THRESH);
  localparam logic [3:0] UNLOCK_T = 4'(UNLOCK_THRESH);
  localparam logic [3:0] LAST_IDX = 4'd13;

  function automatic logic [3:0] seq_val(input logic [3:0] idx);
    case (idx)
      4'd0:    seq_val = 4'd1;
      4'd1:    seq_val = 4'd7;
      4'd2:    seq_val = 4'd11;
      4'd3:    seq_val = 4'd4;
      4'd4:    seq_val = 4'd9;
      4'd5:    seq_val = 4'd2;
      4'd6:    seq_val = 4'd5;
      4'd7:    seq_val = 4'd12;
      4'd8:    seq_val = 4'd6;
      4'd9:    seq_val = 4'd3;
      4'd10:   seq_val = 4'd15;
      4'd11:   seq_val = 4'd1;
      4'd12:   seq_val = 4'd14;
      4'd13:   seq_val = 4'd13;
      default: seq_val = 4'd0;
    endcase
  endfunction

  // Returns {hit, index}; value 1 is ambiguous and 0/8/10 never occur, so no hit.
  function automatic logic [4:0] seed_lookup(input logic [3:0] v);
    case (v)
      4'd7:    seed_lookup = {1'b1, 4'd1};
      4'd11:   seed_lookup = {1'b1, 4'd2};
      4'd4:    seed_lookup = {1'b1, 4'd3};
      4'd9:    seed_lookup = {1'b1, 4'd4};
      4'd2:    seed_lookup = {1'b1, 4'd5};
      4'd5:    seed_lookup = {1'b1, 4'd6};
      4'd12:   seed_lookup = {1'b1, 4'd7};
      4'd6:    seed_lookup = {1'b1, 4'd8};
      4'd3:    seed_lookup = {1'b1, 4'd9};
      4'd15:   seed_lookup = {1'b1, 4'd10};
      4'd14:   seed_lookup = {1'b1, 4'd12};
      4'd13:   seed_lookup = {1'b1, 4'd13};
      default: seed_lookup = 5'd0;
    endcase
  endfunction

  function automatic logic [3:0] next_idx(input logic [3:0] idx);
    next_idx = (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
  endfunction

  state_t             state_r, state_s;
  logic [3:0]         exp_idx_r, exp_idx_s;
  logic [3:0]         good_run_r, good_run_s;
  logic [3:0]         bad_run_r, bad_run_s;
  logic [ERR_W-1:0]   err_count_r, err_count_s;
  logic [MATCH_W-1:0] match_count_r, match_count_s;
  logic               error_pulse_r, error_pulse_s;
  logic               period_pulse_r, period_pulse_s;
  logic               locked_r;
  logic               err_inc_s, match_inc_s, hit_s;
  logic [4:0]         seed_s;

  assign hit_s  = (sample == seq_val(exp_idx_r));
  assign seed_s = seed_lookup(sample);

  // Next-state, alignment tracking and pulse decode for one qualified sample.
  always_comb begin
    state_s        = state_r;
    exp_idx_s      = exp_idx_r;
    good_run_s     = good_run_r;
    bad_run_s      = bad_run_r;
    err_inc_s      = 1'b0;
    match_inc_s    = 1'b0;
    error_pulse_s  = 1'b0;
    period_pulse_s = 1'b0;
    if (sample_valid) begin
      case (state_r)
        SEARCH: begin
          if (seed_s[4]) begin
            state_s    = ACQUIRE;
            exp_idx_s  = next_idx(seed_s[3:0]);
            good_run_s = 4'd1;
          end else begin
            state_s = SEARCH;
          end
        end
        ACQUIRE: begin
          if (hit_s) begin
            exp_idx_s  = next_idx(exp_idx_r);
            good_run_s = good_run_r + 4'd1;
            if (good_run_r + 4'd1 == LOCK_T) begin
              state_s   = LOCKED;
              bad_run_s = 4'd0;
            end else begin
              state_s = ACQUIRE;
            end
          end else begin
            state_s    = SEARCH;
            good_run_s = 4'd0;
          end
        end
        LOCKED: begin
          exp_idx_s = next_idx(exp_idx_r);
          if (hit_s) begin
            match_inc_s    = 1'b1;
            bad_run_s      = 4'd0;
            period_pulse_s = (exp_idx_r == LAST_IDX);
          end else begin
            err_inc_s     = 1'b1;
            error_pulse_s = 1'b1;
            bad_run_s     = bad_run_r + 4'd1;
            if (bad_run_r + 4'd1 == UNLOCK_T) begin
              state_s = SEARCH;
            end else begin
              state_s = LOCKED;
            end
          end
        end
        default: state_s = SEARCH;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Saturating counters; clear overrides any increment on the same edge.
  always_comb begin
    err_count_s   = err_count_r;
    match_count_s = match_count_r;
    if (clear) begin
      err_count_s   = {ERR_W{1'b0}};
      match_count_s = {MATCH_W{1'b0}};
    end else begin
      if (err_inc_s && (err_count_r != {ERR_W{1'b1}})) begin
        err_count_s = err_count_r + ERR_W'(1);
      end else begin
        err_count_s = err_count_r;
      end
      if (match_inc_s && (match_count_r != {MATCH_W{1'b1}})) begin
        match_count_s = match_count_r + MATCH_W'(1);
      end else begin
        match_count_s = match_count_r;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= SEARCH;
      exp_idx_r      <= 4'd0;
      good_run_r     <= 4'd0;
      bad_run_r      <= 4'd0;
      err_count_r    <= {ERR_W{1'b0}};
      match_count_r  <= {MATCH_W{1'b0}};
      error_pulse_r  <= 1'b0;
      period_pulse_r <= 1'b0;
      locked_r       <= 1'b0;
    end else begin
      state_r        <= state_s;
      exp_idx_r      <= exp_idx_s;
      good_run_r     <= good_run_s;
      bad_run_r      <= bad_run_s;
      err_count_r    <= err_count_s;
      match_count_r  <= match_count_s;
      error_pulse_r  <= error_pulse_s;
      period_pulse_r <= period_pulse_s;
      locked_r       <= (state_s == LOCKED);
    end
  end

  assign locked       = locked_r;
  assign error_pulse  = error_pulse_r;
  assign period_pulse = period_pulse_r;
  assign err_count    = err_count_r;
  assign match_count  = match_count_r;
  assign fsm_state    = state_r;

endmodule

// File: tb/tb_rand_seq_checker.sv
// Self-checking bench for rand_seq_checker: table vectors and loops push
// expected outputs into a scoreboard queue, popped one edge later.
module tb_rand_seq_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [3:0]  sample;
  logic        clear;
  logic        locked;
  logic        error_pulse;
  logic        period_pulse;
  logic [7:0]  err_count;
  logic [15:0] match_count;
  logic [1:0]  fsm_state;

  rand_seq_checker dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .clear        (clear),
    .locked       (locked),
    .error_pulse  (error_pulse),
    .period_pulse (period_pulse),
    .err_count    (err_count),
    .match_count  (match_count),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  s;
    logic        c;
    logic [1:0]  st;
    logic        ep;
    logic        pp;
    logic [7:0]  ec;
    logic [15:0] mc;
  } vec_t;

  vec_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [3:0]  seq_tab [14];
  vec_t        tab1 [5];
  vec_t        tab2 [20];

  function automatic vec_t mkv(input logic v, input logic [3:0] s, input logic c,
                               input logic [1:0] st, input logic ep, input logic pp,
                               input logic [7:0] ec, input logic [15:0] mc);
    vec_t r;
    r.v = v; r.s = s; r.c = c; r.st = st; r.ep = ep; r.pp = pp; r.ec = ec; r.mc = mc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic compare_outputs(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".state"},  32'(fsm_state),    32'(e.st));
      check({tag, ".locked"}, 32'(locked),       32'(e.st == 2'd2));
      check({tag, ".errp"},   32'(error_pulse),  32'(e.ep));
      check({tag, ".perp"},   32'(period_pulse), 32'(e.pp));
      check({tag, ".errc"},   32'(err_count),    32'(e.ec));
      check({tag, ".matchc"}, 32'(match_count),  32'(e.mc));
    end
  endtask

  task automatic step(input vec_t vec, input string tag);
    sample_valid = vec.v;
    sample       = vec.s;
    clear        = vec.c;
    exp_q.push_back(vec);
    @(posedge clk);
    #1;
    compare_outputs(tag);
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  initial begin
    int          ti;
    logic [3:0]  val;
    logic [7:0]  ec;
    logic [15:0] mc;

    seq_tab = '{4'd1, 4'd7, 4'd11, 4'd4, 4'd9, 4'd2, 4'd5, 4'd12, 4'd6, 4'd3, 4'd15, 4'd1, 4'd14, 4'd13};

    tab1[0] = mkv(1'b1, 4'd7,  1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    tab1[1] = mkv(1'b0, 4'd3,  1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    tab1[2] = mkv(1'b1, 4'd11, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    tab1[3] = mkv(1'b1, 4'd4,  1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    tab1[4] = mkv(1'b1, 4'd9,  1'b0, 2'd2, 1'b0, 1'b0, 8'd0, 16'd0);

    tab2[0]  = mkv(1'b1, 4'd0,  1'b0, 2'd2, 1'b1, 1'b0, 8'd1, 16'd28);
    tab2[1]  = mkv(1'b1, 4'd5,  1'b0, 2'd2, 1'b0, 1'b0, 8'd1, 16'd29);
    tab2[2]  = mkv(1'b1, 4'd12, 1'b0, 2'd2, 1'b0, 1'b0, 8'd1, 16'd30);
    tab2[3]  = mkv(1'b0, 4'd0,  1'b1, 2'd2, 1'b0, 1'b0, 8'd0, 16'd0);
    tab2[4]  = mkv(1'b1, 4'd0,  1'b0, 2'd2, 1'b1, 1'b0, 8'd1, 16'd0);
    tab2[5]  = mkv(1'b0, 4'd3,  1'b0, 2'd2, 1'b0, 1'b0, 8'd1, 16'd0);
    tab2[6]  = mkv(1'b1, 4'd8,  1'b0, 2'd2, 1'b1, 1'b0, 8'd2, 16'd0);
    tab2[7]  = mkv(1'b1, 4'd10, 1'b0, 2'd0, 1'b1, 1'b0, 8'd3, 16'd0);
    tab2[8]  = mkv(1'b1, 4'd1,  1'b0, 2'd0, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[9]  = mkv(1'b1, 4'd14, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[10] = mkv(1'b1, 4'd13, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[11] = mkv(1'b1, 4'd1,  1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[12] = mkv(1'b1, 4'd9,  1'b0, 2'd0, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[13] = mkv(1'b1, 4'd7,  1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[14] = mkv(1'b1, 4'd11, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[15] = mkv(1'b1, 4'd9,  1'b0, 2'd0, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[16] = mkv(1'b1, 4'd7,  1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[17] = mkv(1'b1, 4'd11, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[18] = mkv(1'b1, 4'd4,  1'b0, 2'd1, 1'b0, 1'b0, 8'd3, 16'd0);
    tab2[19] = mkv(1'b1, 4'd9,  1'b0, 2'd2, 1'b0, 1'b0, 8'd3, 16'd0);

    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = 4'd0;
    clear        = 1'b0;
    #12;
    exp_q.push_back(mkv(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 16'd0));
    compare_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) step(tab1[i], "acquire");

    // Two full periods starting at index 5.
    for (int k = 0; k < 28; k++) begin
      ti  = (5 + k) % 14;
      val = seq_tab[ti];
      step(mkv(1'b1, val, 1'b0, 2'd2, 1'b0, (ti == 13), 8'd0, 16'(k + 1)), "period");
    end

    for (int i = 0; i < 20; i++) step(tab2[i], "errseq");

    // Alternate wrong/right samples while locked to drive err_count into saturation.
    ti = 5;
    ec = 8'd3;
    mc = 16'd0;
    for (int n = 0; n < 260; n++) begin
      if (ec != 8'd255) ec = ec + 8'd1;
      step(mkv(1'b1, 4'd0, 1'b0, 2'd2, 1'b1, 1'b0, ec, mc), "sat_bad");
      ti  = (ti + 1) % 14;
      val = seq_tab[ti];
      mc  = mc + 16'd1;
      step(mkv(1'b1, val, 1'b0, 2'd2, 1'b0, (ti == 13), ec, mc), "sat_good");
      ti  = (ti + 1) % 14;
    end
    check("sat_final_errc", 32'(err_count), 32'd255);

    step(mkv(1'b1, 4'd0, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0, 16'd0), "clear_vs_err");
    ti  = (ti + 1) % 14;
    val = seq_tab[ti];
    step(mkv(1'b1, val, 1'b0, 2'd2, 1'b0, (ti == 13), 8'd0, 16'd1), "post_clear");

    // Asynchronous reset in the middle of a cycle while locked.
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.locked", 32'(locked), 32'd0);
    check("async_rst.state",  32'(fsm_state), 32'd0);
    check("async_rst.errc",   32'(err_count), 32'd0);
    check("async_rst.matchc", 32'(match_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(mkv(1'b1, 4'd1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 16'd0), "rst_search");
    step(mkv(1'b1, 4'd7, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 16'd0), "rst_reseed");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
